id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  ARM instruction-decode stage: sits between IF/ID register and ID/EX pipeline register.
//  Decodes instruction, evaluates condition against NZCV, reads 15x32 register file
//  (written by WB stage), and drives control/data fields captured by ID/EX register.
//  Reports source registers to the hazard unit; squashes control on hazard or failed condition.
// PARAMETERS
//  NUM_REGS  15  architectural GPRs R0..R14 held in file (R15 = PC, not stored)
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst          in   1   synchronous, active-high reset
//  instruction  in  32   instruction from IF/ID register
//  pc_in        in  32   PC (already +4) from IF/ID register
//  status       in   4   {N,Z,C,V} from status register
//  hazard       in   1   hazard unit stall request; zero control outputs
//  wb_en        in   1   writeback enable from WB stage
//  wb_dest      in   4   writeback register index
//  wb_value     in  32   writeback data
//  WB_EN,MEM_R_EN,MEM_W_EN out 1 each  control to ID/EX
//  EXE_CMD      out  4   ALU command
//  B, S         out  1   branch taken-request; update-status flag
//  PC           out 32   pc_in passed through
//  valRn, valRm out 32   register-file read data for src1, src2
//  imm          out  1   instruction[25]
//  shiftOperand out 12   instruction[11:0]
//  signedIMM    out 24   instruction[23:0]
//  dest         out  4   instruction[15:12]
//  src1, src2   out  4   read indices to hazard unit
//  two_src      out  1   src2 is a real operand (~imm | MEM_W_EN)
// BEHAVIOUR
//  Fields: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12].
//  mode 00 data-proc EXE_CMD: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101,
//   AND 0110, ORR 0111, EOR 1000, CMP 0100, TST 0110; WB_EN=1 except CMP/TST; S=instr[20].
//  mode 01 memory, opcode 0100: instr[20]=1 LDR (MEM_R_EN, WB_EN, EXE_CMD 0010, S=0);
//   instr[20]=0 STR (MEM_W_EN, EXE_CMD 0010, S=0). Other opcodes: all control 0.
//  mode 10 branch: B=1, others 0. mode 11: all control 0.
//  Condition EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL per ARM; cond 1111 = fail.
//  Squash: if hazard=1 or condition fails -> WB_EN,MEM_R_EN,MEM_W_EN,B,S,EXE_CMD all 0.
//   Data outputs (valRn, dest, ...) still driven; src1/src2/two_src unaffected by squash.
//  src1=Rn; src2 = Rd when MEM_W_EN (pre-squash) else instruction[3:0].
//  Register file: 15x32. Write on rising clk when wb_en=1 and wb_dest!=15; wb_dest=15 ignored.
//   Read is combinational; same-cycle read of wb_dest with wb_en=1 returns wb_value (bypass).
//   Read index 15 returns pc_in.
//  Reset (rst=1 at clk edge): register Ri <- i (R0=0 ... R14=14); wins over simultaneous write.
//  All outputs are combinational from inputs/register file; no output register, latency 0.
//   After reset, outputs reflect current instruction immediately (no reset-held values).
//  Reset mid-stream: pending wb write in that cycle dropped; file returns to index values.
// TESTING
//  rst 1 cycle, instr ADD R1,R2,R3 (0xE0821003) -> valRn=2, valRm=3, EXE_CMD=0010, WB_EN=1, dest=1.
//  wb_en=1 wb_dest=5 wb_value=0xDEADBEEF, instr reads Rn=5 same cycle -> valRn=0xDEADBEEF; next cycle persists.
//  STR R4,[R6] (0xE5864000) -> MEM_W_EN=1, src2=4, two_src=1, WB_EN=0, EXE_CMD=0010.
//  BEQ (0x0A000010) status Z=0 -> B=0, all control 0; status Z=1 -> B=1, signedIMM=0x000010.
//  CMP R1,#5 (0xE3510005) with hazard=1 -> all control 0, src1=1, two_src=0; hazard=0 -> S=1, EXE_CMD=0100, WB_EN=0.
//  write R7=0x55, then rst with wb_en=1 wb_dest=7 -> R7 reads 7; wb_dest=15 write -> Rn=15 reads pc_in.

Source files
------------

// File: rtl/id_stage.sv
// ARM instruction-decode stage: field extraction, condition evaluation,
// control decode with squash, and a 15x32 register file with WB write port.
module id_stage #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [3:0]        status,
    input  logic              hazard,
    input  logic              wb_en,
    input  logic [3:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    output logic              WB_EN,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic [3:0]        EXE_CMD,
    output logic              B,
    output logic              S,
    output logic [DATA_W-1:0] PC,
    output logic [DATA_W-1:0] valRn,
    output logic [DATA_W-1:0] valRm,
    output logic              imm,
    output logic [11:0]       shiftOperand,
    output logic [23:0]       signedIMM,
    output logic [3:0]        dest,
    output logic [3:0]        src1,
    output logic [3:0]        src2,
    output logic              two_src
);

    logic [DATA_W-1:0] rf_q [0:NUM_REGS-1];

    logic [3:0] cond;
    logic [1:0] mode;
    logic [3:0] opcode;
    logic       s_bit;

    // Pre-squash control decode
    logic       wb_en_d, mem_r_d, mem_w_d, b_d, s_d;
    logic [3:0] cmd_d;
    logic       cond_ok;

    assign cond   = instruction[31:28];
    assign mode   = instruction[27:26];
    assign opcode = instruction[24:21];
    assign s_bit  = instruction[20];

    // ARM condition code check against {N,Z,C,V}; 1111 never executes
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] nzcv);
        logic n, z, cy, v;
        {n, z, cy, v} = nzcv;
        case (c)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = cy;
            4'b0011: cond_pass = ~cy;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = cy & ~z;
            4'b1001: cond_pass = ~cy | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    assign cond_ok = cond_pass(cond, status);

    // Control decode by instruction class; unknown encodings produce no control
    always_comb begin
        wb_en_d = 1'b0;
        mem_r_d = 1'b0;
        mem_w_d = 1'b0;
        b_d     = 1'b0;
        s_d     = 1'b0;
        cmd_d   = 4'b0000;
        case (mode)
            2'b00: begin
                s_d     = s_bit;
                wb_en_d = 1'b1;
                case (opcode)
                    4'b1101: cmd_d = 4'b0001;            // MOV
                    4'b1111: cmd_d = 4'b1001;            // MVN
                    4'b0100: cmd_d = 4'b0010;            // ADD
                    4'b0101: cmd_d = 4'b0011;            // ADC
                    4'b0010: cmd_d = 4'b0100;            // SUB
                    4'b0110: cmd_d = 4'b0101;            // SBC
                    4'b0000: cmd_d = 4'b0110;            // AND
                    4'b1100: cmd_d = 4'b0111;            // ORR
                    4'b0001: cmd_d = 4'b1000;            // EOR
                    4'b1010: begin cmd_d = 4'b0100; wb_en_d = 1'b0; end  // CMP
                    4'b1000: begin cmd_d = 4'b0110; wb_en_d = 1'b0; end  // TST
                    default: begin wb_en_d = 1'b0; s_d = 1'b0; end
                endcase
            end
            2'b01: begin
                // Bit 24 is the pre/post-index flag and does not change the control decode
                if (opcode[2:0] == 3'b100) begin
                    cmd_d = 4'b0010;
                    if (s_bit) begin
                        mem_r_d = 1'b1;
                        wb_en_d = 1'b1;
                    end else begin
                        mem_w_d = 1'b1;
                    end
                end
            end
            2'b10:   b_d = 1'b1;
            default: ;
        endcase
    end

    // Squash control on a stall request or a failed condition
    always_comb begin
        if (hazard || !cond_ok) begin
            WB_EN    = 1'b0;
            MEM_R_EN = 1'b0;
            MEM_W_EN = 1'b0;
            B        = 1'b0;
            S        = 1'b0;
            EXE_CMD  = 4'b0000;
        end else begin
            WB_EN    = wb_en_d;
            MEM_R_EN = mem_r_d;
            MEM_W_EN = mem_w_d;
            B        = b_d;
            S        = s_d;
            EXE_CMD  = cmd_d;
        end
    end

    // Source selection uses the pre-squash store flag so the hazard unit always sees real operands
    assign src1    = instruction[19:16];
    assign src2    = mem_w_d ? instruction[15:12] : instruction[3:0];
    assign two_src = ~instruction[25] | mem_w_d;

    assign PC           = pc_in;
    assign imm          = instruction[25];
    assign shiftOperand = instruction[11:0];
    assign signedIMM    = instruction[23:0];
    assign dest         = instruction[15:12];

    // Index 15 is the PC; a same-cycle write to the read index is forwarded
    assign valRn = (src1 == 4'd15) ? pc_in :
                   (wb_en && wb_dest == src1) ? wb_value : rf_q[src1];
    assign valRm = (src2 == 4'd15) ? pc_in :
                   (wb_en && wb_dest == src2) ? wb_value : rf_q[src2];

    // Register file: reset loads Ri = i and overrides any pending writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= DATA_W'(i);
            end
        end else if (wb_en && wb_dest != 4'd15) begin
            rf_q[wb_dest] <= wb_value;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage: table of decode cases plus register-file sequences.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] pc_in;
    logic [3:0]  status;
    logic        hazard;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic        WB_EN, MEM_R_EN, MEM_W_EN, B, S, imm, two_src;
    logic [3:0]  EXE_CMD, dest, src1, src2;
    logic [31:0] PC, valRn, valRm;
    logic [11:0] shiftOperand;
    logic [23:0] signedIMM;

    int n_checks = 0;
    int n_fail   = 0;

    id_stage dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc_in(pc_in),
        .status(status), .hazard(hazard), .wb_en(wb_en), .wb_dest(wb_dest),
        .wb_value(wb_value), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .EXE_CMD(EXE_CMD), .B(B), .S(S), .PC(PC), .valRn(valRn), .valRm(valRm),
        .imm(imm), .shiftOperand(shiftOperand), .signedIMM(signedIMM), .dest(dest),
        .src1(src1), .src2(src2), .two_src(two_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD}
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [3:0]  nzcv;
        logic        hz;
        logic [8:0]  ctl;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        two;
        logic [31:0] rn;
        logic [31:0] rm;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; instruction = 32'hE0821003; pc_in = 32'h100; status = 4'b0000;
        hazard = 1'b0; wb_en = 1'b0; wb_dest = 4'd0; wb_value = 32'h0;

        //                 name        instr         nzcv     hz  ctl             s1  s2  two rn        rm
        vecs.push_back('{"add",      32'hE0821003, 4'b0000, 0, 9'b1_0_0_0_0_0010, 2,  3,  1, 32'd2,   32'd3});
        vecs.push_back('{"add_r14",  32'hE08E100D, 4'b0000, 0, 9'b1_0_0_0_0_0010, 14, 13, 1, 32'd14,  32'd13});
        vecs.push_back('{"str",      32'hE5864000, 4'b0000, 0, 9'b0_0_1_0_0_0010, 6,  4,  1, 32'd6,   32'd4});
        vecs.push_back('{"str_hz",   32'hE5864000, 4'b0000, 1, 9'b0_0_0_0_0_0000, 6,  4,  1, 32'd6,   32'd4});
        vecs.push_back('{"ldr",      32'hE5964000, 4'b0000, 0, 9'b1_1_0_0_0_0010, 6,  0,  1, 32'd6,   32'd0});
        vecs.push_back('{"mem_oth",  32'hE4064000, 4'b0000, 0, 9'b0_0_0_0_0_0000, 6,  0,  1, 32'd6,   32'd0});
        vecs.push_back('{"beq_nz",   32'h0A000010, 4'b0000, 0, 9'b0_0_0_0_0_0000, 0,  0,  0, 32'd0,   32'd0});
        vecs.push_back('{"beq_z",    32'h0A000010, 4'b0100, 0, 9'b0_0_0_1_0_0000, 0,  0,  0, 32'd0,   32'd0});
        vecs.push_back('{"cmp_hz",   32'hE3510005, 4'b0000, 1, 9'b0_0_0_0_0_0000, 1,  5,  0, 32'd1,   32'd5});
        vecs.push_back('{"cmp",      32'hE3510005, 4'b0000, 0, 9'b0_0_0_0_1_0100, 1,  5,  0, 32'd1,   32'd5});
        vecs.push_back('{"movs",     32'hE3B00007, 4'b0000, 0, 9'b1_0_0_0_1_0001, 0,  7,  0, 32'd0,   32'd7});
        vecs.push_back('{"mvn_pc",   32'hE1E0200F, 4'b0000, 0, 9'b1_0_0_0_0_1001, 0,  15, 1, 32'd0,   32'h100});
        vecs.push_back('{"subne_f",  32'h10443005, 4'b0100, 0, 9'b0_0_0_0_0_0000, 4,  5,  1, 32'd4,   32'd5});
        vecs.push_back('{"subne_p",  32'h10443005, 4'b0000, 0, 9'b1_0_0_0_0_0100, 4,  5,  1, 32'd4,   32'd5});
        vecs.push_back('{"andsgt_p", 32'hC0121003, 4'b1001, 0, 9'b1_0_0_0_1_0110, 2,  3,  1, 32'd2,   32'd3});
        vecs.push_back('{"andsgt_f", 32'hC0121003, 4'b1000, 0, 9'b0_0_0_0_0_0000, 2,  3,  1, 32'd2,   32'd3});
        vecs.push_back('{"never",    32'hF0821003, 4'b0000, 0, 9'b0_0_0_0_0_0000, 2,  3,  1, 32'd2,   32'd3});
        vecs.push_back('{"orrhi",    32'h81821003, 4'b0010, 0, 9'b1_0_0_0_0_0111, 2,  3,  1, 32'd2,   32'd3});
        vecs.push_back('{"eorlt",    32'hB0221003, 4'b1000, 0, 9'b1_0_0_0_0_1000, 2,  3,  1, 32'd2,   32'd3});
        vecs.push_back('{"tst",      32'hE1120003, 4'b0000, 0, 9'b0_0_0_0_1_0110, 2,  3,  1, 32'd2,   32'd3});
        vecs.push_back('{"adccs",    32'h20A21003, 4'b0010, 0, 9'b1_0_0_0_0_0011, 2,  3,  1, 32'd2,   32'd3});
        vecs.push_back('{"sbc",      32'hE0C21003, 4'b0000, 0, 9'b1_0_0_0_0_0101, 2,  3,  1, 32'd2,   32'd3});
        vecs.push_back('{"mode11",   32'hEE000000, 4'b0000, 0, 9'b0_0_0_0_0_0000, 0,  0,  0, 32'd0,   32'd0});

        tick();
        rst = 1'b0;
        #1;

        // Decode table against the freshly reset register file
        foreach (vecs[i]) begin
            instruction = vecs[i].instr;
            status      = vecs[i].nzcv;
            hazard      = vecs[i].hz;
            #1;
            check({vecs[i].name, ".ctl"},  {23'd0, WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD}, {23'd0, vecs[i].ctl});
            check({vecs[i].name, ".src1"}, {28'd0, src1}, {28'd0, vecs[i].s1});
            check({vecs[i].name, ".src2"}, {28'd0, src2}, {28'd0, vecs[i].s2});
            check({vecs[i].name, ".two"},  {31'd0, two_src}, {31'd0, vecs[i].two});
            check({vecs[i].name, ".valRn"}, valRn, vecs[i].rn);
            check({vecs[i].name, ".valRm"}, valRm, vecs[i].rm);
            check({vecs[i].name, ".dest"}, {28'd0, dest}, {28'd0, vecs[i].instr[15:12]});
            check({vecs[i].name, ".fields"}, {7'd0, imm, signedIMM}, {7'd0, vecs[i].instr[25], vecs[i].instr[23:0]});
            check({vecs[i].name, ".shop"}, {20'd0, shiftOperand}, {20'd0, vecs[i].instr[11:0]});
            check({vecs[i].name, ".pc"}, PC, 32'h100);
        end
        status = 4'b0000;
        hazard = 1'b0;

        // Same-cycle write forwarding to R5, then the stored value persists
        @(negedge clk);
        instruction = 32'hE0851003;
        wb_en = 1'b1; wb_dest = 4'd5; wb_value = 32'hDEADBEEF;
        #1;
        check("bypass.valRn", valRn, 32'hDEADBEEF);
        check("bypass.valRm", valRm, 32'd3);
        tick();
        wb_en = 1'b0;
        #1;
        check("persist.valRn", valRn, 32'hDEADBEEF);

        // Write R7, then reset with a competing write to R7
        wb_en = 1'b1; wb_dest = 4'd7; wb_value = 32'h55;
        tick();
        wb_en = 1'b0;
        instruction = 32'hE0871003;
        #1;
        check("r7_write", valRn, 32'h55);
        rst = 1'b1; wb_en = 1'b1; wb_dest = 4'd7; wb_value = 32'h99;
        tick();
        rst = 1'b0; wb_en = 1'b0;
        #1;
        check("r7_after_rst", valRn, 32'd7);
        instruction = 32'hE0851003;
        #1;
        check("r5_after_rst", valRn, 32'd5);

        // Write to index 15 is dropped; reading 15 returns pc_in even during that write
        pc_in = 32'h200;
        instruction = 32'hE08F1003;
        wb_en = 1'b1; wb_dest = 4'd15; wb_value = 32'h1234;
        #1;
        check("r15_bypass", valRn, 32'h200);
        tick();
        wb_en = 1'b0;
        #1;
        check("r15_read", valRn, 32'h200);
        check("r15_rm", valRm, 32'd3);
        check("r15_pc", PC, 32'h200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
